bus_slave_regs: RTL

BUS_SLAVE_REGS -- requirements
Module: bus_slave_regs

---
 rtl/bus_slave_regs.sv | 133 +++++++++++++
 1 files changed

// File: rtl/bus_slave_regs.sv
// Register-file bus slave: R0..R6 read/write, R7 read-only access counter.
// Each access waits WAIT_CYCLES cycles, then answers with a one-cycle rdy_.
`ifndef WORD_ADDR_BUS
`define WORD_ADDR_BUS 29:0
`endif
`ifndef WORD_DATA_BUS
`define WORD_DATA_BUS 31:0
`endif
`ifndef ENABLE_
`define ENABLE_ 1'b0
`endif
`ifndef DISABLE_
`define DISABLE_ 1'b1
`endif
`ifndef READ
`define READ 1'b1
`endif
`ifndef WRITE
`define WRITE 1'b0
`endif

module bus_slave_regs #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cs_,
    input  logic                  as_,
    input  logic                  rw,
    input  logic [`WORD_ADDR_BUS] addr,
    input  logic [`WORD_DATA_BUS] wrData,
    output logic [`WORD_DATA_BUS] rdData,
    output logic                  rdy_
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK
    } state_t;

    localparam logic [3:0] WAIT_LOAD =
        (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t      state;
    logic [3:0]  wait_cnt;
    logic [2:0]  sel;
    logic        is_read;
    logic [31:0] wdata;
    logic [31:0] regs [0:6];
    logic [15:0] acc_count;

    logic        req;
    logic [2:0]  ack_sel;
    logic        ack_read;
    logic [31:0] ack_value;
    logic        unused_addr;

    assign req = (cs_ == `ENABLE_) && (as_ == `ENABLE_);
    assign unused_addr = ^addr[29:3];

    // With no wait cycles, ACK is entered straight from IDLE, so the
    // read value must come from the live inputs rather than the latches.
    assign ack_sel  = (state == IDLE) ? addr[2:0] : sel;
    assign ack_read = (state == IDLE) ? (rw == `READ) : is_read;

    always_comb begin
        ack_value = '0;
        if (ack_read) begin
            if (ack_sel == 3'd7)
                ack_value = {16'h0000, acc_count};
            else
                ack_value = regs[ack_sel];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rdy_      <= `DISABLE_;
            rdData    <= '0;
            wait_cnt  <= '0;
            acc_count <= '0;
            sel       <= '0;
            is_read   <= 1'b0;
            wdata     <= '0;
            for (int i = 0; i < 7; i++)
                regs[i] <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req) begin
                        sel     <= addr[2:0];
                        is_read <= (rw == `READ);
                        wdata   <= wrData;
                        if (WAIT_CYCLES == 0) begin
                            state  <= ACK;
                            rdy_   <= `ENABLE_;
                            rdData <= ack_value;
                        end else begin
                            state    <= WAIT;
                            wait_cnt <= WAIT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (!req) begin
                        state    <= IDLE;
                        wait_cnt <= '0;
                    end else if (wait_cnt == 4'd0) begin
                        state  <= ACK;
                        rdy_   <= `ENABLE_;
                        rdData <= ack_value;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ACK: begin
                    state     <= IDLE;
                    rdy_      <= `DISABLE_;
                    rdData    <= '0;
                    acc_count <= acc_count + 16'd1;
                    if (!is_read && sel != 3'd7)
                        regs[sel] <= wdata;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
